// File: rtl/clkdiv_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_bank
//  Description : Bank of NCH independent programmable clock dividers running
//                from one system clock. Each channel emits a registered
//                divided clock (period starts high) and a one-cycle tick in
//                the last cycle of every period. Divisors are written at
//                runtime and applied only at a period boundary, so the
//                divided clock never glitches.
//  Revision    : 1.0  initial release
// ============================================================================
module clkdiv_bank #(
  parameter int              NCH         = 4,
  parameter int              DW          = 16,
  parameter int              DEFAULT_DIV = 4,
  parameter logic [NCH-1:0]  EN_DEFAULT  = '1,
  localparam int             CW          = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_ch,
  input  logic [DW-1:0]   wr_div,
  input  logic [NCH-1:0]  en,
  input  logic            sync,
  output logic [NCH-1:0]  divclk,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  pend,
  output logic            wr_err
);

  localparam logic [DW-1:0] c_DEF_DIV = DW'(DEFAULT_DIV);
  localparam logic [DW-1:0] c_ONE     = DW'(1);
  localparam logic [DW-1:0] c_TWO     = DW'(2);

  logic w_ch_ok;
  logic w_wr_ok;
  logic w_wr_bad;
  logic r_wr_err;
  logic w_unused;

  // EN_DEFAULT only documents the intended tie-off of en; it has no logic.
  assign w_unused = ^EN_DEFAULT;

  // Write qualification: divisors below 2 and out-of-range channels are refused.
  always_comb begin
    w_ch_ok  = ({{(32-CW){1'b0}}, wr_ch} < 32'(NCH));
    w_wr_ok  = wr_en && (wr_div >= c_TWO) && w_ch_ok;
    w_wr_bad = wr_en && !w_wr_ok;
  end

  // Rejected-write flag, a one-cycle pulse following the offending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= w_wr_bad;
    end
  end

  assign wr_err = r_wr_err;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DW-1:0] r_p;
    logic [DW-1:0] r_n;
    logic [DW-1:0] r_pnd;
    logic          r_pend;
    logic          r_div;
    logic          r_tick;
    logic          w_hit;
    logic          w_wrap;
    logic [DW-1:0] w_n_new;
    logic [DW-1:0] w_n_cur;
    logic [DW-1:0] w_p_next;

    // Next-phase computation; a wrap (natural or sync) is the only point
    // where a pending divisor may replace the active one.
    always_comb begin
      w_hit    = w_wr_ok && (wr_ch == CW'(gi));
      w_n_new  = r_pend ? r_pnd : r_n;
      w_wrap   = sync || (r_p == r_n - c_ONE);
      w_n_cur  = w_wrap ? w_n_new : r_n;
      w_p_next = w_wrap ? '0 : r_p + c_ONE;
    end

    // Channel state: the write update is last so a write landing on a wrap
    // survives as the new pending divisor rather than being consumed.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_n    <= c_DEF_DIV;
        r_p    <= c_DEF_DIV - c_ONE;
        r_pnd  <= c_DEF_DIV;
        r_pend <= 1'b0;
        r_div  <= 1'b0;
        r_tick <= 1'b0;
      end else begin
        if (!en[gi]) begin
          // Parked on the last phase so re-enabling wraps into a fresh period.
          r_n    <= w_n_new;
          r_p    <= w_n_new - c_ONE;
          r_pend <= 1'b0;
          r_div  <= 1'b0;
          r_tick <= 1'b0;
        end else begin
          r_n    <= w_n_cur;
          r_p    <= w_p_next;
          if (w_wrap) begin
            r_pend <= 1'b0;
          end
          r_div  <= (w_p_next < (w_n_cur >> 1));
          r_tick <= (w_p_next == (w_n_cur - c_ONE));
        end
        if (w_hit) begin
          r_pnd  <= wr_div;
          r_pend <= 1'b1;
        end
      end
    end

    assign divclk[gi] = r_div;
    assign tick[gi]   = r_tick;
    assign pend[gi]   = r_pend;
  end

endmodule
`default_nettype wire

// File: tb/tb_clkdiv_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clkdiv_bank
//  Description : Directed bench for clkdiv_bank (NCH=3, DW=4, DEFAULT_DIV=4)
//                with a per-cycle expected-output scoreboard and literal
//                waveform checks for the key scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_clkdiv_bank;

  localparam int NCH = 3;
  localparam int DW  = 4;
  localparam int DEF = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [1:0]      wr_ch;
  logic [DW-1:0]   wr_div;
  logic [NCH-1:0]  en;
  logic            sync;
  logic [NCH-1:0]  divclk;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  pend;
  logic            wr_err;

  typedef struct {
    string          tag;
    logic [NCH-1:0] div;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] pd;
    logic           err;
  } exp_t;

  exp_t           sbq[$];
  int             total = 0;
  int             bad   = 0;
  int             m_n[NCH];
  int             m_p[NCH];
  int             m_nxt[NCH];
  bit             m_pd[NCH];
  logic [NCH-1:0] s_div;
  logic [NCH-1:0] s_tick;
  logic [15:0]    cap_div;
  logic [15:0]    cap_tick;
  int             t0;
  int             t1;
  int             guard;

  clkdiv_bank #(
    .NCH         (NCH),
    .DW          (DW),
    .DEFAULT_DIV (DEF),
    .EN_DEFAULT  (3'b111)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .en     (en),
    .sync   (sync),
    .divclk (divclk),
    .tick   (tick),
    .pend   (pend),
    .wr_err (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs after the coming edge, derived from the current inputs.
  task automatic model_push(input string tag);
    exp_t e;
    bit   wrap;
    e.tag = tag;
    e.div = '0;
    e.tk  = '0;
    e.pd  = '0;
    e.err = !rst && wr_en && ((wr_div < 2) || (wr_ch >= NCH));
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_n[c]  = DEF;
        m_p[c]  = DEF - 1;
        m_pd[c] = 1'b0;
      end else begin
        if (!en[c]) begin
          if (m_pd[c]) begin
            m_n[c]  = m_nxt[c];
            m_pd[c] = 1'b0;
          end
          m_p[c] = m_n[c] - 1;
        end else begin
          wrap = sync || (m_p[c] == m_n[c] - 1);
          if (wrap) begin
            if (m_pd[c]) begin
              m_n[c]  = m_nxt[c];
              m_pd[c] = 1'b0;
            end
            m_p[c] = 0;
          end else begin
            m_p[c] = m_p[c] + 1;
          end
          e.div[c] = (m_p[c] < m_n[c] / 2);
          e.tk[c]  = (m_p[c] == m_n[c] - 1);
        end
        if (wr_en && (wr_div >= 2) && (wr_ch == c)) begin
          m_nxt[c] = int'(wr_div);
          m_pd[c]  = 1'b1;
        end
      end
      e.pd[c] = m_pd[c];
    end
    sbq.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    model_push(tag);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".divclk"}, 32'(divclk), 32'(e.div));
    chk({e.tag, ".tick"},   32'(tick),   32'(e.tk));
    chk({e.tag, ".pend"},   32'(pend),   32'(e.pd));
    chk({e.tag, ".wr_err"}, 32'(wr_err), 32'(e.err));
    s_div  = divclk;
    s_tick = tick;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; en = '1; sync = 1'b0;
    for (int i = 0; i < 3; i++) step("reset");
    rst = 1'b0;

    // Default divisor: 1,1,0,0 from the first edge, ticks on cycles 4, 8, 12.
    for (int i = 0; i < 12; i++) begin
      step("run4");
      cap_div[i]  = s_div[1];
      cap_tick[i] = s_tick[1];
    end
    chk("pattern4_div",  32'(cap_div[11:0]),  32'h333);
    chk("pattern4_tick", 32'(cap_tick[11:0]), 32'h888);

    // Mid-period write of N=5 to channel 1.
    step("idle");
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 4'd5;
    step("wr_ch1_n5");
    wr_en = 1'b0;
    for (int i = 0; i < 16; i++) step("ch1_n5");

    // Rejected writes: divisor 1, then out-of-range channel.
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 4'd1;
    step("err_div");
    wr_ch = 2'd3; wr_div = 4'd6;
    step("err_ch");
    wr_en = 1'b0;
    step("err_clr");

    // Two writes before a wrap (last wins), then one issued on a wrap cycle.
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 4'd6;
    step("wr_ch0_n6");
    wr_div = 4'd8;
    step("wr_ch0_n8");
    wr_en = 1'b0;
    guard = 0;
    while (!(m_p[0] == m_n[0] - 1) && guard < 20) begin
      step("wait_wrap");
      guard++;
    end
    chk("wrap_found", 32'(guard < 20), 32'd1);
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 4'd3;
    step("wr_on_wrap");
    wr_en = 1'b0;
    cap_div[0]  = s_div[0];
    cap_tick[0] = s_tick[0];
    for (int i = 1; i < 8; i++) begin
      step("ch0_n8");
      cap_div[i]  = s_div[0];
      cap_tick[i] = s_tick[0];
    end
    chk("n8_div",  32'(cap_div[7:0]),  32'h0F);
    chk("n8_tick", 32'(cap_tick[7:0]), 32'h80);
    chk("n8_pend_held", 32'(pend[0]), 32'd1);
    for (int i = 0; i < 6; i++) step("ch0_n3");

    // Channel 1 to N=7, let it drift against channel 0 (N=3), then sync.
    wr_en = 1'b1; wr_ch = 2'd1; wr_div = 4'd7;
    step("wr_ch1_n7");
    wr_en = 1'b0;
    for (int i = 0; i < 20; i++) step("drift");
    sync = 1'b1;
    step("sync");
    sync = 1'b0;
    chk("sync_div",  32'(s_div[1:0]),  32'h3);
    chk("sync_tick", 32'(s_tick[1:0]), 32'h0);
    t0 = 0;
    t1 = 0;
    for (int i = 2; i <= 8; i++) begin
      step("post_sync");
      if (s_tick[0] && t0 == 0) t0 = i;
      if (s_tick[1] && t1 == 0) t1 = i;
    end
    chk("sync_tick_n3", 32'(t0), 32'd3);
    chk("sync_tick_n7", 32'(t1), 32'd7);

    // Channel 2 disabled for 10 cycles with an N=15 write in the middle.
    en = 3'b011;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        wr_en = 1'b1; wr_ch = 2'd2; wr_div = 4'd15;
      end else begin
        wr_en = 1'b0;
      end
      step("ch2_off");
    end
    chk("off_div",  32'(s_div[2]),  32'd0);
    chk("off_pend", 32'(pend[2]),   32'd0);
    en = 3'b111;
    for (int i = 0; i < 15; i++) begin
      step("ch2_n15");
      cap_div[i]  = s_div[2];
      cap_tick[i] = s_tick[2];
    end
    chk("n15_div",  32'(cap_div[14:0]),  32'h007F);
    chk("n15_tick", 32'(cap_tick[14:0]), 32'h4000);
    step("ch2_wrap");
    chk("n15_rewrap", 32'(s_div[2]), 32'd1);

    // Reset with a write in flight: write is lost, defaults return.
    rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 4'd9;
    step("rst2_wr");
    wr_en = 1'b0;
    step("rst2");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
